// File: rtl/sha256d_sequencer_pkg.sv
// Shared constants, FSM state type and padding helpers for sha256d_sequencer.
// Holds the SHA-256 IV, the message bit lengths, and pure functions that build padded 512-bit blocks.
package sha256d_sequencer_pkg;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [63:0] HDR_LEN_BITS    = 64'd640;
  localparam logic [63:0] DIGEST_LEN_BITS = 64'd256;

  typedef enum logic [2:0] {
    IDLE,
    C1_START,
    C1_WAIT,
    C2_START,
    C2_WAIT,
    C3_START,
    C3_WAIT,
    DONE
  } seq_state_t;

  // Second block of the 80-byte header: last 16 bytes, 0x80 marker, zeros, bit length.
  function automatic logic [511:0] pad_hdr_tail(input logic [127:0] tail);
    return {tail, 8'h80, 312'b0, HDR_LEN_BITS};
  endfunction

  // Single block for hashing a 32-byte digest.
  function automatic logic [511:0] pad_digest(input logic [255:0] h);
    return {h, 8'h80, 184'b0, DIGEST_LEN_BITS};
  endfunction

endpackage

// File: rtl/sha256d_sequencer.sv
// sha256d_sequencer: runs an external sha256_compress three times to produce SHA256(SHA256(header)).
// Latency: digest_valid 202 cycles after the header handshake with a 66-cycle compressor; one header in flight.
// Backpressure: hdr_ready only in IDLE; digest held in DONE until digest_ready. SHA256D_BYTESWAP_EN: byte-reversed digest.
module sha256d_sequencer
  import sha256d_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         hdr_valid,
  output logic         hdr_ready,
  input  logic [639:0] header,
  output logic         cmp_start,
  output logic [511:0] cmp_chunk,
  output logic [255:0] cmp_state_in,
  input  logic [255:0] cmp_state_out,
  input  logic         cmp_finish,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest
);

  seq_state_t   state;
  logic [127:0] hdr_tail_q;
  logic [255:0] result_fmt;

`ifdef SHA256D_BYTESWAP_EN
  // Bitcoin display order: raw byte 31 ends up in the top byte.
  for (genvar i = 0; i < 32; i++) begin : g_bswap
    assign result_fmt[8*i +: 8] = cmp_state_out[255-8*i -: 8];
  end
`else
  assign result_fmt = cmp_state_out;
`endif

  assign hdr_ready = (state == IDLE);

  // The first 64 header bytes live in cmp_chunk during C1; only the tail needs its own register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hdr_tail_q   <= '0;
      cmp_start    <= 1'b0;
      cmp_chunk    <= '0;
      cmp_state_in <= '0;
      digest_valid <= 1'b0;
      digest       <= '0;
    end else begin
      cmp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_valid) begin
            hdr_tail_q   <= header[127:0];
            cmp_chunk    <= header[639:128];
            cmp_state_in <= SHA256_IV;
            cmp_start    <= 1'b1;
            state        <= C1_START;
          end
        end
        C1_START: state <= C1_WAIT;
        C1_WAIT: begin
          if (cmp_finish) begin
            cmp_chunk    <= pad_hdr_tail(hdr_tail_q);
            cmp_state_in <= cmp_state_out;
            cmp_start    <= 1'b1;
            state        <= C2_START;
          end
        end
        C2_START: state <= C2_WAIT;
        C2_WAIT: begin
          if (cmp_finish) begin
            cmp_chunk    <= pad_digest(cmp_state_out);
            cmp_state_in <= SHA256_IV;
            cmp_start    <= 1'b1;
            state        <= C3_START;
          end
        end
        C3_START: state <= C3_WAIT;
        C3_WAIT: begin
          if (cmp_finish) begin
            digest       <= result_fmt;
            digest_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256d_sequencer.sv
// Bench for sha256d_sequencer with a behavioural 66-cycle SHA-256 compressor and a digest scoreboard.
module tb_sha256d_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         hdr_valid;
  logic         hdr_ready;
  logic [639:0] header;
  logic         cmp_start;
  logic [511:0] cmp_chunk;
  logic [255:0] cmp_state_in;
  logic [255:0] cmp_state_out;
  logic         cmp_finish;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  logic spur_req = 1'b0;
  logic [255:0] exp_q[$];

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [639:0] GENESIS = {
    32'h01000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
    32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
  };

`ifdef SHA256D_BYTESWAP_EN
  localparam logic [255:0] GENESIS_DIGEST = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
`else
  localparam logic [255:0] GENESIS_DIGEST = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
`endif

  sha256d_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .hdr_valid     (hdr_valid),
    .hdr_ready     (hdr_ready),
    .header        (header),
    .cmp_start     (cmp_start),
    .cmp_chunk     (cmp_chunk),
    .cmp_state_in  (cmp_state_in),
    .cmp_state_out (cmp_state_out),
    .cmp_finish    (cmp_finish),
    .digest_valid  (digest_valid),
    .digest_ready  (digest_ready),
    .digest        (digest)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
            st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
  endfunction

  // Standard SHA-256 over the 80-byte message, applied twice.
  function automatic logic [255:0] model_sha256d(input logic [639:0] hdr);
    logic [255:0] h1, h2, h3, r;
    h1 = sha_compress(IV, hdr[639:128]);
    h2 = sha_compress(h1, {hdr[127:0], 8'h80, 312'b0, 64'd640});
    h3 = sha_compress(IV, {h2, 8'h80, 184'b0, 64'd256});
    r = h3;
`ifdef SHA256D_BYTESWAP_EN
    for (int i = 0; i < 32; i++) r[8*i +: 8] = h3[255-8*i -: 8];
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compressor model: finish pulse 66 cycles after the start cycle; reset on the same net.
  initial begin : compressor
    int cnt;
    logic [511:0] cap_chunk;
    logic [255:0] cap_state;
    cnt = -1;
    cmp_finish = 1'b0;
    cmp_state_out = '0;
    forever begin
      @(posedge clk); #1;
      cmp_finish = 1'b0;
      if (reset) begin
        cnt = -1;
      end else begin
        if (cnt >= 0) cnt++;
        if (cnt == 66) begin
          cmp_finish = 1'b1;
          cmp_state_out = sha_compress(cap_state, cap_chunk);
          cnt = -1;
        end
        if (cmp_start) begin
          cap_chunk = cmp_chunk;
          cap_state = cmp_state_in;
          cnt = 0;
        end
        if (spur_req) begin
          cmp_finish = 1'b1;
          cmp_state_out = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // Monitor: scoreboard pops on digest acceptance, plus latency, start count and WAIT stability.
  initial begin : monitor
    logic dv_prev, acc_prev, in_wait, stable;
    logic [511:0] cap_chunk;
    logic [255:0] cap_state;
    logic [255:0] e;
    int cyc, hs_cyc, start_cnt;
    dv_prev = 1'b0; acc_prev = 1'b0; in_wait = 1'b0; stable = 1'b1;
    cyc = 0; hs_cyc = 0; start_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        dv_prev = 1'b0; acc_prev = 1'b0; in_wait = 1'b0; start_cnt = 0;
      end else begin
        if (hdr_valid && hdr_ready) begin
          hs_cnt++;
          hs_cyc = cyc;
        end
        if (in_wait) begin
          if (cmp_chunk !== cap_chunk || cmp_state_in !== cap_state) stable = 1'b0;
          if (cmp_finish) begin
            chk("wait_inputs_stable", stable, 1);
            in_wait = 1'b0;
          end
        end
        if (cmp_start) begin
          start_cnt++;
          cap_chunk = cmp_chunk;
          cap_state = cmp_state_in;
          stable = 1'b1;
          in_wait = 1'b1;
        end
        if (digest_valid && !dv_prev) chk("latency", cyc - hs_cyc, 202);
        if (dv_prev && !acc_prev) chk("digest_valid_held", digest_valid, 1);
        if (digest_valid && digest_ready) begin
          if (exp_q.size() == 0) begin
            chk("digest_without_header", digest_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("digest", digest, e);
            chk("start_pulses", start_cnt, 3);
          end
          start_cnt = 0;
        end
        dv_prev = digest_valid;
        acc_prev = digest_valid && digest_ready;
      end
    end
  end

  task automatic send(input logic [639:0] h, input logic [255:0] e, input bit keep);
    hdr_valid = 1'b1;
    header = h;
    for (int i = 0; i < 2000 && !hdr_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("hdr_ready_wait", hdr_ready, 1);
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!keep) hdr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1500 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic spurious_finish();
    @(posedge clk); #2 spur_req = 1'b1;
    @(posedge clk); #2 spur_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_cmp_start"}, cmp_start, 0);
    chk({tag, "_digest_valid"}, digest_valid, 0);
    chk({tag, "_digest"}, digest, 0);
    chk({tag, "_cmp_chunk"}, cmp_chunk, 0);
    chk({tag, "_cmp_state_in"}, cmp_state_in, 0);
  endtask

  initial begin : stimulus
    logic [255:0] last_exp;
    int hs_before;
    reset = 1'b1;
    hdr_valid = 1'b0;
    header = '0;
    digest_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_cleared("reset");
    chk("reset_hdr_ready", hdr_ready, 1);

    @(posedge clk); #1;
    send(GENESIS, GENESIS_DIGEST, 1'b0);
    drain();
    send({640{1'b0}}, model_sha256d({640{1'b0}}), 1'b0);
    drain();
    send({640{1'b1}}, model_sha256d({640{1'b1}}), 1'b0);
    drain();

    // Backpressure: header held valid, consumer stalled.
    digest_ready = 1'b0;
    hs_before = hs_cnt;
    send(GENESIS, GENESIS_DIGEST, 1'b1);
    repeat (500) @(posedge clk);
    #1;
    chk("bp_single_accept", hs_cnt - hs_before, 1);
    chk("bp_digest_valid", digest_valid, 1);
    chk("bp_hdr_ready", hdr_ready, 0);
    chk("bp_digest", digest, GENESIS_DIGEST);
    hdr_valid = 1'b0;
    spurious_finish();
    chk("done_spur_digest", digest, GENESIS_DIGEST);
    chk("done_spur_valid", digest_valid, 1);
    chk("done_spur_hdr_ready", hdr_ready, 0);
    digest_ready = 1'b1;
    drain();

    last_exp = GENESIS_DIGEST;
    spurious_finish();
    chk("idle_spur_digest", digest, last_exp);
    chk("idle_spur_hdr_ready", hdr_ready, 1);
    chk("idle_spur_cmp_start", cmp_start, 0);
    chk("idle_spur_digest_valid", digest_valid, 0);

    // Reset in C2_WAIT, 100 cycles after the handshake.
    send(GENESIS, GENESIS_DIGEST, 1'b0);
    repeat (99) @(posedge clk);
    #3 reset = 1'b1;
    exp_q.delete();
    #1;
    chk_cleared("midreset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    send(GENESIS, GENESIS_DIGEST, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256d_sequencer.md
SHA256D_SEQUENCER -- requirements
Module: sha256d_sequencer

Interface
REQ-001 No parameters; all widths fixed by SHA-256 and the 80-byte Bitcoin header.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 hdr_valid  input  1  header[] holds a block header to hash.
REQ-005 hdr_ready  output  1  sequencer accepts a header this cycle.
REQ-006 header  input  640  80-byte header, byte 0 in bits [639:632].
REQ-007 cmp_start  output  1  one-cycle start pulse to sha256_compress.
REQ-008 cmp_chunk  output  512  512-bit message block to the compressor, big-endian words.
REQ-009 cmp_state_in  output  256  chaining state to the compressor, H0 in [255:224].
REQ-010 cmp_state_out  input  256  compressor result, valid in the cycle cmp_finish is high.
REQ-011 cmp_finish  input  1  one-cycle compressor done pulse.
REQ-012 digest_valid  output  1  digest[] holds SHA256(SHA256(header)).
REQ-013 digest_ready  input  1  consumer accepts the digest.
REQ-014 digest  output  256  double-hash result.

Function
REQ-015 FSM states: IDLE, C1_START, C1_WAIT, C2_START, C2_WAIT, C3_START, C3_WAIT, DONE.
REQ-016 hdr_ready = 1 only in IDLE; hdr_valid&&hdr_ready latches header into a 640-bit register and enters C1_START.
REQ-017 Cx_START: cmp_start = 1 for exactly that cycle, then unconditionally Cx_WAIT; cmp_start = 0 in all other states.
REQ-018 cmp_chunk and cmp_state_in are registered and held stable from Cx_START until the cycle after cmp_finish.
REQ-019 C1: chunk = header[639:128]; state_in = SHA-256 IV (6a09e667 ... 5be0cd19).
REQ-020 C2: chunk = {header[127:0], 8'h80, 312'b0, 64'd640}; state_in = C1 result.
REQ-021 C3: chunk = {C2 result, 8'h80, 184'b0, 64'd256}; state_in = IV.
REQ-022 In Cx_WAIT, cmp_finish latches cmp_state_out into the midstate/result register and advances to the next START (C3_WAIT goes to DONE); cmp_finish in any other state is ignored.
REQ-023 DONE: digest_valid = 1, digest stable; digest_valid&&digest_ready returns to IDLE; header not accepted in that same cycle.
REQ-024 With a 66-cycle compressor (start to finish), digest_valid rises 202 cycles after the header handshake cycle.
REQ-025 Additions modulo 2^32 happen only in the compressor; the sequencer performs no arithmetic beyond constant padding.

Reset
REQ-026 On reset: state = IDLE, hdr_ready = 1 after release, cmp_start = 0, digest_valid = 0, digest = 0, cmp_chunk = 0, cmp_state_in = 0.
REQ-027 Reset mid-operation abandons the hash; no digest_valid is produced for that header; the first post-reset header hashes correctly, with the compressor reset on the same reset net.

Configuration
REQ-028 SHA256D_BYTESWAP_EN defined: digest presented byte-reversed (Bitcoin display order, byte 31 of the raw hash in [255:248]).
REQ-029 SHA256D_BYTESWAP_EN undefined: digest = raw C3 result, H0 in [255:224]; FSM and timing are identical either way.

Structure
REQ-030 sha256_pkg holds: IV constant, state enum type, padding-length constants (640, 256), and a pure function building padded chunks.
REQ-031 No sub-module; sha256_compress is instantiated beside this block in sha256d_top, not inside it.

Verification
REQ-032 Genesis header (version 1, merkle 4a5e1e4b..., time 0x495fab29, bits 0x1d00ffff, nonce 0x7c2bac1d): with SHA256D_BYTESWAP_EN, digest = 000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f; without it, digest = 6fe28c0ab6f1b372...0000000000.
REQ-033 All-zero header, then all-FF header: digest matches the software SHA256d model; exactly three cmp_start pulses occur per header.
REQ-034 hdr_valid held high with digest_ready low for 500 cycles: a single header is accepted, digest_valid stays high, and hdr_ready stays 0 until digest_ready.
REQ-035 Reset asserted in C2_WAIT at cycle 100: outputs clear asynchronously; the next genesis header yields the correct digest.
REQ-036 Spurious cmp_finish in DONE or IDLE: no state change and digest unchanged; cmp_chunk and cmp_state_in checked stable throughout each WAIT.
